// File: rtl/kp_midi_voice_ctrl.sv
// MIDI note-on/off parser driving Karplus-Strong voice tuning, velocity and trigger.
// Optional string damping through decay_out when KP_MIDI_DAMP_EN is defined.
module kp_midi_voice_ctrl #(
  parameter logic [3:0]  MIDI_CH    = 4'd0,
  parameter int          TRIG_HOLD  = 8,
  parameter logic [11:0] DAMP_DECAY = 12'd256
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic [7:0]  midi_data,
  input  logic        midi_valid,
  input  logic [11:0] decay_in,
  output logic        trig,
  output logic [6:0]  velocity,
  output logic [10:0] delay_length,
  output logic [6:0]  note,
  output logic        note_active,
  output logic [11:0] decay_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_rs_valid;
  logic        r_rs_on;
  logic [6:0]  r_d1;
  logic [7:0]  r_hold;

  logic        w_byte;
  logic        w_status;
  logic        w_our_status;
  logic        w_exec;
  logic        w_on;
  logic        w_off;
  logic        w_na_next;
  logic [6:0]  w_cl;
  logic [6:0]  w_k;
  logic [6:0]  w_oct;
  logic [9:0]  w_base;
  logic [15:0] w_shift;
  logic [15:0] w_sum;
  logic        w_unused_sum;

  // Real-time bytes are invisible to the parser
  assign w_byte       = midi_valid && (midi_data < 8'hF8);
  assign w_status     = w_byte && midi_data[7];
  assign w_our_status = (midi_data[7:5] == 3'b100)
                        && (midi_data[3:0] == MIDI_CH);

  assign w_exec = w_byte && !midi_data[7] && (r_state == WAIT_D2);
  assign w_on   = w_exec && r_rs_on && (midi_data[6:0] != 7'd0);
  assign w_off  = w_exec && !w_on && (w_cl == note);

  assign w_na_next = w_on ? 1'b1 : (w_off ? 1'b0 : note_active);

  assign w_cl = (r_d1 < 7'd31)  ? 7'd31 :
                (r_d1 > 7'd107) ? 7'd107 : r_d1;

  assign w_k   = w_cl % 7'd12;
  assign w_oct = w_cl / 7'd12;

  always_comb begin
    w_base = 10'd734;
    unique case (w_k)
      7'd0:    w_base = 10'd734;
      7'd1:    w_base = 10'd693;
      7'd2:    w_base = 10'd654;
      7'd3:    w_base = 10'd617;
      7'd4:    w_base = 10'd583;
      7'd5:    w_base = 10'd550;
      7'd6:    w_base = 10'd519;
      7'd7:    w_base = 10'd490;
      7'd8:    w_base = 10'd462;
      7'd9:    w_base = 10'd436;
      7'd10:   w_base = 10'd412;
      7'd11:   w_base = 10'd389;
      default: w_base = 10'd734;
    endcase
  end

  // Octave shift is 0..6 after the clamp, so 16 bits never overflow
  assign w_shift = {6'd0, w_base} << (7'd8 - w_oct);
  assign w_sum   = w_shift + 16'd8;
  assign w_unused_sum = ^{w_sum[15], w_sum[3:0]};

`ifdef KP_MIDI_DAMP_EN
  localparam logic [11:0] DECAY_RST = DAMP_DECAY;
`else
  localparam logic [11:0] DECAY_RST = 12'd0;
`endif

  always_ff @(posedge a_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rs_valid   <= 1'b0;
      r_rs_on      <= 1'b0;
      r_d1         <= 7'd0;
      r_hold       <= 8'd0;
      trig         <= 1'b1;
      velocity     <= 7'd0;
      note         <= 7'd69;
      delay_length <= 11'd218;
      note_active  <= 1'b0;
      decay_out    <= DECAY_RST;
    end else begin
`ifdef KP_MIDI_DAMP_EN
      decay_out <= w_na_next ? decay_in : DAMP_DECAY;
`else
      decay_out <= decay_in;
`endif
      note_active <= w_na_next;

      if (r_hold > 8'd1) begin
        r_hold <= r_hold - 8'd1;
      end else if (r_hold == 8'd1) begin
        r_hold <= 8'd0;
        trig   <= 1'b1;
      end

      if (w_status) begin
        if (w_our_status) begin
          r_rs_valid <= 1'b1;
          r_rs_on    <= midi_data[4];
          r_state    <= WAIT_D1;
        end else begin
          r_rs_valid <= 1'b0;
          r_state    <= IDLE;
        end
      end else if (w_byte) begin
        unique case (r_state)
          IDLE: begin
            if (r_rs_valid) begin
              r_d1    <= midi_data[6:0];
              r_state <= WAIT_D2;
            end
          end
          WAIT_D1: begin
            r_d1    <= midi_data[6:0];
            r_state <= WAIT_D2;
          end
          WAIT_D2: begin
            r_state <= IDLE;
            if (w_on) begin
              note         <= w_cl;
              velocity     <= midi_data[6:0];
              delay_length <= w_sum[14:4];
              trig         <= 1'b0;
              r_hold       <= 8'(TRIG_HOLD);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kp_midi_voice_ctrl.sv
// Directed bench for kp_midi_voice_ctrl; expected values hand-computed.
// Define KP_MIDI_DAMP_EN to exercise the damping build.
module tb_kp_midi_voice_ctrl;

  logic        a_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  midi_data = 8'd0;
  logic        midi_valid = 1'b0;
  logic [11:0] decay_in = 12'd4000;
  logic        trig;
  logic [6:0]  velocity;
  logic [10:0] delay_length;
  logic [6:0]  note;
  logic        note_active;
  logic [11:0] decay_out;

  int n_chk = 0;
  int n_pass = 0;
  int n_low;
  int n_pre;

`ifdef KP_MIDI_DAMP_EN
  localparam int DEC_RST = 256;
  localparam int DEC_OFF = 256;
`else
  localparam int DEC_RST = 0;
  localparam int DEC_OFF = 4000;
`endif

  kp_midi_voice_ctrl dut (
    .a_clk        (a_clk),
    .reset        (reset),
    .midi_data    (midi_data),
    .midi_valid   (midi_valid),
    .decay_in     (decay_in),
    .trig         (trig),
    .velocity     (velocity),
    .delay_length (delay_length),
    .note         (note),
    .note_active  (note_active),
    .decay_out    (decay_out)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called on a negedge; strobe is sampled at the next posedge
  task automatic send(input logic [7:0] b);
    midi_data  = b;
    midi_valid = 1'b1;
    @(negedge a_clk);
    midi_valid = 1'b0;
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (trig == 1'b0 && n < 300) begin
      n++;
      @(negedge a_clk);
    end
  endtask

  initial begin
    @(negedge a_clk);
    @(negedge a_clk);
    chk("rst_trig", trig, 1);
    chk("rst_vel", velocity, 0);
    chk("rst_note", note, 69);
    chk("rst_dl", delay_length, 218);
    chk("rst_na", note_active, 0);
    chk("rst_decay", decay_out, DEC_RST);
    reset = 1'b0;

    // 1: basic note-on
    send(8'h90); send(8'h45); send(8'h64);
    chk("t1_note", note, 69);
    chk("t1_dl", delay_length, 218);
    chk("t1_vel", velocity, 100);
    chk("t1_na", note_active, 1);
    chk("t1_trig", trig, 0);
    chk("t1_decay", decay_out, 4000);
    measure_low(n_low);
    chk("t1_low", n_low, 8);
    decay_in = 12'd1234;
    @(negedge a_clk);
    chk("t1_decay_f", decay_out, 1234);
    decay_in = 12'd4000;
    @(negedge a_clk);

    // 2: running status
    send(8'h90); send(8'h3C); send(8'h40);
    chk("t2_dl60", delay_length, 367);
    chk("t2_note60", note, 60);
    measure_low(n_low);
    chk("t2_low_a", n_low, 8);
    send(8'h1F); send(8'h7F);
    chk("t2_note31", note, 31);
    chk("t2_dl31", delay_length, 1960);
    chk("t2_vel", velocity, 127);
    chk("t2_trig", trig, 0);
    measure_low(n_low);
    chk("t2_low_b", n_low, 8);

    // 3: note-off handling
    send(8'h90); send(8'h3C); send(8'h40);
    measure_low(n_low);
    send(8'h90); send(8'h3C); send(8'h00);
    chk("t3_na_off", note_active, 0);
    chk("t3_dl", delay_length, 367);
    chk("t3_vel", velocity, 64);
    chk("t3_trig", trig, 1);
    chk("t3_damp", decay_out, DEC_OFF);
    send(8'h90); send(8'h3C); send(8'h40);
    measure_low(n_low);
    send(8'h80); send(8'h3E); send(8'h40);
    chk("t3_nomatch_na", note_active, 1);
    chk("t3_nomatch_note", note, 60);
    chk("t3_live_decay", decay_out, 4000);
    send(8'h3C); send(8'h40);
    chk("t3_match80_na", note_active, 0);

    // 4: filtering and clamp
    send(8'h91); send(8'h45); send(8'h64);
    chk("t4_ch_note", note, 60);
    chk("t4_ch_vel", velocity, 64);
    chk("t4_ch_trig", trig, 1);
    send(8'hB0); send(8'h45); send(8'h64);
    chk("t4_cc_note", note, 60);
    chk("t4_cc_na", note_active, 0);
    send(8'h90); send(8'hF8); send(8'h45); send(8'hF8); send(8'h64);
    chk("t4_rt_note", note, 69);
    chk("t4_rt_dl", delay_length, 218);
    chk("t4_rt_vel", velocity, 100);
    measure_low(n_low);
    chk("t4_rt_low", n_low, 8);
    send(8'h90); send(8'h78); send(8'h10);
    chk("t4_clamp_note", note, 107);
    chk("t4_clamp_dl", delay_length, 24);
    chk("t4_clamp_vel", velocity, 16);
    measure_low(n_low);

    // 5: reset mid-message, then retrigger
    send(8'h90); send(8'h3C);
    reset = 1'b1;
    @(negedge a_clk);
    reset = 1'b0;
    chk("t5_rst_note", note, 69);
    chk("t5_rst_decay", decay_out, DEC_RST);
    send(8'h40);
    chk("t5_lone_note", note, 69);
    chk("t5_lone_vel", velocity, 0);
    chk("t5_lone_trig", trig, 1);
    send(8'h3C); send(8'h40);
    chk("t5_nors_na", note_active, 0);
    send(8'h90); send(8'h45); send(8'h64);
    n_pre = 1;
    send(8'h90);
    if (trig == 1'b0) n_pre++;
    send(8'h3C);
    if (trig == 1'b0) n_pre++;
    send(8'h40);
    chk("t5_retrig_note", note, 60);
    measure_low(n_low);
    chk("t5_retrig_low", n_pre + n_low, 11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
